// File: rtl/dff1.sv
// dff1: single WIDTH-bit D flip-flop.
// Synchronous active-high reset loads RST_VAL.
module dff1 #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage register: reset has priority over d.
  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: tb/tb_dff1.sv
// tb_dff1: directed checks of dff1.
// Covers 1-bit, 8-bit and a 4-stage chain.
module tb_dff1;

  logic       clk;
  logic       rst;
  logic       d;
  logic       q;
  logic       si;
  logic [3:0] y;
  logic [7:0] d8;
  logic [7:0] q8;

  int tests;
  int fails;

  dff1 u_bit (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  dff1 u_s0 (.clk(clk), .rst(rst), .d(si),   .q(y[0]));
  dff1 u_s1 (.clk(clk), .rst(rst), .d(y[0]), .q(y[1]));
  dff1 u_s2 (.clk(clk), .rst(rst), .d(y[1]), .q(y[2]));
  dff1 u_s3 (.clk(clk), .rst(rst), .d(y[2]), .q(y[3]));

  dff1 #(.WIDTH(8), .RST_VAL(8'hA5)) u_byte (
    .clk (clk),
    .rst (rst),
    .d   (d8),
    .q   (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    d   = 1'b1;
    si  = 1'b1;
    d8  = 8'hFF;

    // reset dominates d
    tick();
    chk("rst_e1_q", {7'd0, q}, 8'h00);
    chk("rst_e1_q8", q8, 8'hA5);
    chk("rst_e1_chain", {4'd0, y}, 8'h00);
    tick();
    chk("rst_e2_q", {7'd0, q}, 8'h00);
    chk("rst_e2_q8", q8, 8'hA5);

    // release: first edge captures d
    rst = 1'b0;
    d   = 1'b0;
    si  = 1'b0;
    d8  = 8'h3C;
    tick();
    chk("seq0_q", {7'd0, q}, 8'h00);
    chk("seq0_q8", q8, 8'h3C);
    chk("sh1", {4'd0, y}, 8'h00);

    d = 1'b1; si = 1'b1; d8 = 8'hC3;
    tick();
    chk("seq1_q", {7'd0, q}, 8'h01);
    chk("seq1_q8", q8, 8'hC3);
    chk("sh2", {4'd0, y}, 8'h01);

    d = 1'b1; si = 1'b1; d8 = 8'h5A;
    tick();
    chk("seq2_q", {7'd0, q}, 8'h01);
    chk("seq2_q8", q8, 8'h5A);
    chk("sh3", {4'd0, y}, 8'h03);

    d = 1'b0; si = 1'b0; d8 = 8'h00;
    tick();
    chk("seq3_q", {7'd0, q}, 8'h00);
    chk("seq3_q8", q8, 8'h00);
    chk("sh4", {4'd0, y}, 8'h06);

    si = 1'b0;
    d  = 1'b1;
    tick();
    chk("sh5", {4'd0, y}, 8'h0C);
    chk("set_q", {7'd0, q}, 8'h01);
    tick();
    chk("sh6", {4'd0, y}, 8'h08);
    tick();
    chk("sh7", {4'd0, y}, 8'h00);

    // d glitch between edges: no effect
    #2 d = 1'b0;
    #2 chk("glitch_mid", {7'd0, q}, 8'h01);
    d = 1'b1;
    tick();
    chk("glitch_edge", {7'd0, q}, 8'h01);

    // rst pulse between edges: no effect
    #2 rst = 1'b1;
    #2 chk("rpulse_mid", {7'd0, q}, 8'h01);
    rst = 1'b0;
    tick();
    chk("rpulse_edge", {7'd0, q}, 8'h01);

    // falling edge: no effect
    d = 1'b0;
    @(negedge clk);
    #1 chk("negedge", {7'd0, q}, 8'h01);

    // rst held through edges in mid-operation
    d   = 1'b1;
    d8  = 8'h77;
    rst = 1'b1;
    tick();
    chk("midrst_q", {7'd0, q}, 8'h00);
    chk("midrst_q8", q8, 8'hA5);
    tick();
    chk("midrst_hold", {7'd0, q}, 8'h00);

    // deassert: no recovery cycle
    #2 rst = 1'b0;
    #2 chk("deassert_mid", {7'd0, q}, 8'h00);
    tick();
    chk("recover_q", {7'd0, q}, 8'h01);
    chk("recover_q8", q8, 8'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
